// File: rtl/qlearn_action_selector.sv
`default_nettype none
// ============================================================================
// Module     : qlearn_action_selector
// Description: Epsilon-greedy action selector. Reads all Q-values of a state,
//              finds the signed argmax, then emits the greedy or an
//              LFSR-chosen random action. Optional: QSEL_EPS_DECAY_EN.
// Revision   : 1.0 - initial release
// ============================================================================
module qlearn_action_selector #(
    parameter int          DATA_WIDTH    = 16,
    parameter int          STATES_WIDTH  = 4,
    parameter int          ACTIONS       = 3,
    parameter int          ACTIONS_WIDTH = 2,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter logic [7:0]  EPS_MIN       = 8'd4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_start,
    input  logic                                  i_finish,
    input  logic                                  i_valid,
    input  logic [STATES_WIDTH-1:0]               i_st,
    input  logic [7:0]                            i_epsilon,
    output logic                                  o_ready,
    output logic [STATES_WIDTH+ACTIONS_WIDTH-1:0] o_q_raddr,
    output logic                                  o_q_rd,
    input  logic [DATA_WIDTH-1:0]                 i_q_rdata,
    output logic                                  o_valid,
    output logic [ACTIONS_WIDTH-1:0]              o_at,
    output logic                                  o_greedy,
    output logic [DATA_WIDTH-1:0]                 o_max_q
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_DRAIN  = 3'd2,
        S_DECIDE = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    localparam logic [ACTIONS_WIDTH-1:0] c_last_a  = ACTIONS_WIDTH'(ACTIONS - 1);
    localparam logic [ACTIONS_WIDTH:0]   c_actions = (ACTIONS_WIDTH + 1)'(ACTIONS);

    state_t                         state_q, state_d;
    logic [STATES_WIDTH-1:0]        st_q, st_d;
    logic [ACTIONS_WIDTH-1:0]       a_cnt_q, a_cnt_d;
    logic                           rd_pend_q, rd_pend_d;
    logic [ACTIONS_WIDTH-1:0]       rd_idx_q, rd_idx_d;
    logic signed [DATA_WIDTH-1:0]   best_val_q, best_val_d;
    logic [ACTIONS_WIDTH-1:0]       best_a_q, best_a_d;
    logic [15:0]                    lfsr_q, lfsr_d;
    logic [ACTIONS_WIDTH-1:0]       at_q, at_d;
    logic                           greedy_q, greedy_d;
    logic [DATA_WIDTH-1:0]          maxq_q, maxq_d;
    logic [7:0]                     w_eps_eff;
    logic                           w_explore;
    logic [ACTIONS_WIDTH-1:0]       w_rnd_raw, w_rnd_a;

`ifdef QSEL_EPS_DECAY_EN
    logic [7:0] eps_q, eps_d;

    // A fresh load always beats the per-decision decrement.
    always_comb begin
        eps_d = eps_q;
        if (i_start) begin
            eps_d = i_epsilon;
        end else if ((state_q == S_OUT) && (eps_q > EPS_MIN)) begin
            eps_d = eps_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eps_q <= 8'd0;
        end else begin
            eps_q <= eps_d;
        end
    end

    assign w_eps_eff = eps_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{i_start, EPS_MIN};
    assign w_eps_eff  = i_epsilon;
`endif

    assign w_explore = (lfsr_q[7:0] < w_eps_eff);
    assign w_rnd_raw = lfsr_q[8+ACTIONS_WIDTH-1:8];
    assign w_rnd_a   = ({1'b0, w_rnd_raw} >= c_actions) ? (w_rnd_raw - c_actions[ACTIONS_WIDTH-1:0])
                                                        : w_rnd_raw;

    always_comb begin
        state_d    = state_q;
        st_d       = st_q;
        a_cnt_d    = a_cnt_q;
        rd_pend_d  = 1'b0;
        rd_idx_d   = a_cnt_q;
        best_val_d = best_val_q;
        best_a_d   = best_a_q;
        at_d       = at_q;
        greedy_d   = greedy_q;
        maxq_d     = maxq_q;
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        // Data arrives one cycle after its strobe; strict '>' keeps the lowest index on ties.
        if (rd_pend_q && ((rd_idx_q == '0) || ($signed(i_q_rdata) > best_val_q))) begin
            best_val_d = $signed(i_q_rdata);
            best_a_d   = rd_idx_q;
        end

        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    st_d    = i_st;
                    a_cnt_d = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                rd_pend_d = 1'b1;
                a_cnt_d   = a_cnt_q + 1'b1;
                if (a_cnt_q == c_last_a) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN:  state_d = S_DECIDE;
            S_DECIDE: begin
                at_d     = w_explore ? w_rnd_a : best_a_q;
                greedy_d = ~w_explore;
                maxq_d   = best_val_q;
                state_d  = S_OUT;
            end
            S_OUT:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (i_finish) begin
            state_d   = S_IDLE;
            rd_pend_d = 1'b0;
            at_d      = at_q;
            greedy_d  = greedy_q;
            maxq_d    = maxq_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            st_q       <= '0;
            a_cnt_q    <= '0;
            rd_pend_q  <= 1'b0;
            rd_idx_q   <= '0;
            best_val_q <= '0;
            best_a_q   <= '0;
            lfsr_q     <= LFSR_SEED;
            at_q       <= '0;
            greedy_q   <= 1'b0;
            maxq_q     <= '0;
        end else begin
            state_q    <= state_d;
            st_q       <= st_d;
            a_cnt_q    <= a_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_idx_q   <= rd_idx_d;
            best_val_q <= best_val_d;
            best_a_q   <= best_a_d;
            lfsr_q     <= lfsr_d;
            at_q       <= at_d;
            greedy_q   <= greedy_d;
            maxq_q     <= maxq_d;
        end
    end

    assign o_ready   = (state_q == S_IDLE);
    assign o_q_rd    = (state_q == S_READ);
    assign o_q_raddr = (state_q == S_READ) ? {st_q, a_cnt_q} : '0;
    assign o_valid   = (state_q == S_OUT);
    assign o_at      = at_q;
    assign o_greedy  = greedy_q;
    assign o_max_q   = maxq_q;

endmodule
`default_nettype wire

// File: tb/tb_qlearn_action_selector.sv
`default_nettype none
// ============================================================================
// Module     : tb_qlearn_action_selector
// Description: Self-checking bench with a cycle-level policy model of the
//              selector plus directed scenarios. Honours QSEL_EPS_DECAY_EN.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_qlearn_action_selector;

    localparam int          DW   = 16;
    localparam int          SW   = 4;
    localparam int          NA   = 3;
    localparam int          AW   = 2;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [7:0]  EMIN = 8'd4;

    logic          clk = 1'b0;
    logic          rst, i_start, i_finish, i_valid;
    logic [SW-1:0] i_st;
    logic [7:0]    i_epsilon;
    logic          o_ready, o_q_rd, o_valid, o_greedy;
    logic [SW+AW-1:0] o_q_raddr;
    logic [DW-1:0] i_q_rdata, o_max_q;
    logic [AW-1:0] o_at;

    qlearn_action_selector #(
        .DATA_WIDTH(DW), .STATES_WIDTH(SW), .ACTIONS(NA), .ACTIONS_WIDTH(AW),
        .LFSR_SEED(SEED), .EPS_MIN(EMIN)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_finish(i_finish),
        .i_valid(i_valid), .i_st(i_st), .i_epsilon(i_epsilon),
        .o_ready(o_ready), .o_q_raddr(o_q_raddr), .o_q_rd(o_q_rd),
        .i_q_rdata(i_q_rdata), .o_valid(o_valid), .o_at(o_at),
        .o_greedy(o_greedy), .o_max_q(o_max_q)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] qmem [0:63];
    always @(posedge clk) if (o_q_rd) i_q_rdata <= qmem[o_q_raddr];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Policy model: counts cycles since acceptance instead of tracking FSM states.
    logic [15:0]          m_lfsr;
    bit                   m_busy;
    int                   m_cnt;
    logic [SW-1:0]        m_st;
    logic [7:0]           m_eps;
    logic [AW-1:0]        e_at;
    logic                 e_greedy;
    logic [DW-1:0]        e_max;
    logic signed [DW-1:0] m_best;
    int                   m_ba;
    logic [7:0]           m_eps_use;
    bit                   m_was_out;
    bit                   chk_en = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_lfsr = SEED; m_busy = 0; m_cnt = 0; m_eps = 8'd0;
            e_at = '0; e_greedy = 1'b0; e_max = '0;
        end else begin
            m_was_out = m_busy && (m_cnt == NA + 2);
            if (i_finish) begin
                m_busy = 0;
            end else if (!m_busy) begin
                if (i_valid) begin m_busy = 1; m_cnt = 0; m_st = i_st; end
            end else if (m_cnt == NA + 2) begin
                m_busy = 0;
            end else begin
                if (m_cnt == NA + 1) begin
                    m_best = $signed(qmem[{m_st, AW'(0)}]);
                    m_ba   = 0;
                    for (int a = 1; a < NA; a++)
                        if ($signed(qmem[{m_st, AW'(a)}]) > m_best) begin
                            m_best = $signed(qmem[{m_st, AW'(a)}]);
                            m_ba   = a;
                        end
`ifdef QSEL_EPS_DECAY_EN
                    m_eps_use = m_eps;
`else
                    m_eps_use = i_epsilon;
`endif
                    if (int'(m_lfsr[7:0]) < int'(m_eps_use)) begin
                        e_at = AW'(int'(m_lfsr[8+AW-1:8]) % NA); e_greedy = 1'b0;
                    end else begin
                        e_at = AW'(m_ba); e_greedy = 1'b1;
                    end
                    e_max = m_best;
                end
                m_cnt++;
            end
            if (i_start) m_eps = i_epsilon;
            else if (m_was_out && (m_eps > EMIN)) m_eps = m_eps - 8'd1;
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", o_ready, !m_busy);
            chk("valid", o_valid, m_busy && (m_cnt == NA + 2));
            chk("q_rd", o_q_rd, m_busy && (m_cnt < NA));
            if (m_busy && (m_cnt < NA)) chk("raddr", o_q_raddr, {m_st, AW'(m_cnt)});
            chk("at", o_at, e_at);
            chk("greedy", o_greedy, e_greedy);
            chk("max_q", o_max_q, e_max);
        end
    end

    int raddr_q[$];

    task automatic request(input logic [SW-1:0] st, output int acc);
        bit ok = 0;
        i_st = st; i_valid = 1'b1; acc = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (o_ready) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        acc = cyc;
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_result(output int vcyc);
        vcyc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_q_rd) raddr_q.push_back(int'(o_q_raddr));
            if (o_valid) begin vcyc = cyc; break; end
        end
        if (vcyc < 0) chk("valid_timeout", 0, 1);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    int acc, vc, n_exp, n_bad, nv;
    bit seen [0:3];
    int exp6 [8] = '{9, 8, 7, 6, 5, 4, 4, 4};

    initial begin
        for (int i = 0; i < 64; i++) qmem[i] = DW'($urandom_range(0, 65535));
        qmem[20] = 16'd100; qmem[21] = -16'sd20; qmem[22] = 16'd300;
        qmem[24] = -16'sd7; qmem[25] = -16'sd7; qmem[26] = -16'sd9;
        rst = 1; i_start = 0; i_finish = 0; i_valid = 0; i_st = '0; i_epsilon = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst = 0; chk_en = 1;
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_q_rd", o_q_rd, 0);
        chk("rst_max_q", o_max_q, 0);

        // Greedy argmax, latency and address sequence.
        raddr_q.delete();
        request(4'd5, acc); wait_result(vc);
        chk("t1_latency", vc - acc, 6);
        chk("t1_nreads", raddr_q.size(), 3);
        if (raddr_q.size() == 3) begin
            chk("t1_addr0", raddr_q[0], 20); chk("t1_addr1", raddr_q[1], 21); chk("t1_addr2", raddr_q[2], 22);
        end
        chk("t1_at", o_at, 2); chk("t1_greedy", o_greedy, 1); chk("t1_max", o_max_q, 300);
        step();

        // Ties and negative values.
        request(4'd6, acc); wait_result(vc);
        chk("t2_at", o_at, 0); chk("t2_max", o_max_q, 16'hFFF9); chk("t2_greedy", o_greedy, 1);
        step();

        // Full exploration.
        i_epsilon = 8'd255;
`ifdef QSEL_EPS_DECAY_EN
        i_start = 1; step(); i_start = 0;
`endif
        n_exp = 0; n_bad = 0; seen = '{0, 0, 0, 0};
        for (int i = 0; i < 300; i++) begin
            request(SW'(i % 16), acc); wait_result(vc);
            if (!o_greedy) n_exp++;
            if (o_at >= 2'd3) n_bad++;
            seen[o_at] = 1;
            step();
        end
`ifndef QSEL_EPS_DECAY_EN
        chk("t3_explore_ge295", n_exp >= 295, 1);
`endif
        chk("t3_at_range", n_bad, 0);
        chk("t3_seen_all", seen[0] && seen[1] && seen[2], 1);
        i_epsilon = 8'd0;

        // Abort during the second strobe.
        request(4'd3, acc); step();
        chk("t4_second_strobe", o_q_rd, 1);
        i_finish = 1; step(); i_finish = 0;
        chk("t4_rd_off", o_q_rd, 0); chk("t4_ready", o_ready, 1);
        nv = 0;
        repeat (12) begin @(negedge clk); if (o_valid) nv++; end
        chk("t4_no_valid", nv, 0);
        // Valid and finish together in IDLE: nothing accepted.
        step(); i_valid = 1; i_finish = 1; i_st = 4'd9;
        step(); step(); i_valid = 0; i_finish = 0;
        chk("t4_finish_wins", o_ready, 1);
        request(4'd7, acc); wait_result(vc);
        chk("t4_recover_latency", vc - acc, 6);
        step();

        // Held valid with a changing state index.
        nv = 0;
        for (int c = 0; c < 15; c++) begin
            i_st = SW'(c); i_valid = 1;
            @(negedge clk); if (o_valid) nv++;
            step();
        end
        i_valid = 0;
        repeat (10) begin @(negedge clk); if (o_valid) nv++; end
        chk("t5_pulses", nv, 3);
        step();

        // Reset mid-operation.
        request(4'd2, acc); step();
        rst = 1; step(); rst = 0;
        chk("rst_mid_ready", o_ready, 1); chk("rst_mid_max", o_max_q, 0);
        repeat (10) @(negedge clk);
        step();

`ifdef QSEL_EPS_DECAY_EN
        i_epsilon = 8'd10; i_start = 1; step(); i_start = 0;
        chk("t6_load", dut.eps_q, 10);
        for (int i = 0; i < 8; i++) begin
            request(SW'(i), acc); wait_result(vc); step();
            chk("t6_decay", dut.eps_q, exp6[i]);
        end
        i_epsilon = 8'd200;
        request(4'd1, acc); step();
        i_start = 1; step(); i_start = 0;
        chk("t6_reload", dut.eps_q, 200);
        wait_result(vc); step();
        chk("t6_after_reload", dut.eps_q, 199);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
